if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage and IF/ID pipeline register for the 5-stage MIPS core. Drives PC and a
//  single-outstanding instruction-memory request. Holds the IF/ID register under hazard-unit
//  stall and flushes it on branch redirect from ID. Produces the IF/ID fields the hazard unit
//  consumes: rs, rt and the branch flag.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  ADDR_W    32             PC / imem address width
//  INSN_W    32             instruction width (fixed MIPS encoding; only 32 supported)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  stall          in   1       hazard-unit stall: hold PC and IF/ID
//  redirect_valid in   1       taken branch/jump resolved in ID
//  redirect_pc    in   ADDR_W  target PC for redirect
//  imem_req       out  1       request valid to instruction memory
//  imem_addr      out  ADDR_W  request address (= pc)
//  imem_ready     in   1       imem accepts request this cycle (handshake = req & ready)
//  imem_rvalid    in   1       read data valid (>=1 cycle after accept)
//  imem_rdata     in   INSN_W  instruction word
//  ifid_valid     out  1       IF/ID holds a live instruction
//  ifid_pc4       out  ADDR_W  PC+4 of IF/ID instruction
//  ifid_instr     out  INSN_W  instruction; 32'h0 (NOP) when invalid
//  ifid_rs        out  5       instr[25:21]; 0 when invalid
//  ifid_rt        out  5       instr[20:16]; 0 when invalid
//  ifid_br        out  1       valid & opcode in {BEQ 6'b000100, BNE 6'b000101}
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, discard=0, skid empty, all ifid_* = 0, imem_req=0 in reset.
//  Redirect qualifier: redir = redirect_valid & ~stall; redirect_valid is ignored while stall=1.
//  FSM (one request outstanding at most):
//   FETCH: imem_req = ~redir. On req&ready: pc<=pc+4, ->WAIT. On redir: pc<=redirect_pc, stay.
//   WAIT : on redir: pc<=redirect_pc, discard<=1. On rvalid: if discard (or redir same cycle)
//          drop data, discard<=0, ->FETCH; elif ~stall load IF/ID, ->FETCH; else skid<=data,->HOLD.
//   HOLD : on redir: drop skid, pc<=redirect_pc, ->FETCH. elif ~stall: skid->IF/ID, ->FETCH.
//  IF/ID update each cycle: stall=1 -> hold all fields. Else redir -> bubble (valid=0, fields 0).
//   Else load if a non-discarded response or skid is delivered, otherwise bubble.
//  Latency: accept->IF/ID valid = imem latency + 1 cycle; peak 1 instr / 2 cycles.
//  pc+4 wraps modulo 2^ADDR_W; no exception. imem_rvalid outside WAIT is a protocol error (ignored).
//  Async reset mid-WAIT: pending response is dropped by imem reset; FSM restarts at RESET_PC.
// CONFIGURATION
//  IF_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with stall=1) and
//   perf_flush_cnt[31:0] (redir events), saturating at 32'hFFFF_FFFF, cleared by rst_n.
//  IF_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared header mips_defs.vh: OP_BEQ, OP_BNE, INSN_NOP, field bit positions, fetch-FSM state
//   encodings (FETCH/WAIT/HOLD).
//  Sub-module ifid_skid: one-entry skid buffer (load, drain, drop, full flag).
// TESTING
//  1 Reset, imem_ready=1, latency 1 -> addrs 0,4,8 issued; ifid_valid pulses every 2nd cycle.
//  2 stall=1 for 3 cycles while rvalid arrives -> IF/ID frozen, data in skid, no new req;
//    stall=0 -> skid word in IF/ID next cycle.
//  3 redir (target 32'h40) in WAIT, rvalid next cycle -> word dropped, next req addr 32'h40,
//    ifid_valid=0.
//  4 redirect_valid=1 with stall=1 -> ignored; pc and IF/ID unchanged.
//  5 IF/ID holds BEQ $1,$2 -> ifid_br=1, rs=1, rt=2; after bubble rs=rt=0, br=0.
//  6 rst_n low mid-WAIT -> all ifid_* 0 immediately; first req after release at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: MIPS opcodes, field positions, NOP word
// and fetch FSM state encodings.
package if_stage_pkg;

  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [31:0] INSN_NOP = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic logic is_branch(input logic [31:0] insn);
    return (insn[OP_HI:OP_LO] == OP_BEQ) ||
           (insn[OP_HI:OP_LO] == OP_BNE);
  endfunction

endpackage

// File: rtl/if_stage_skid.sv
// One-entry skid buffer parking an instruction word while ID is stalled.
// Load wins over drain/drop; full flag reports occupancy.
module ifid_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         drop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (drain_i || drop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: single-outstanding imem fetch, stall/flush.
// Define IF_PERF_EN to add saturating stall/flush performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [INSN_W-1:0] ifid_instr,
  output logic [4:0]        ifid_rs,
  output logic [4:0]        ifid_rt,
`ifdef IF_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              ifid_br
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              discard_q, discard_d;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [INSN_W-1:0] instr_q, instr_d;

  logic              redir, accept;
  logic              deliver_rsp;
  logic              skid_load, skid_drain, skid_drop;
  logic              skid_full;
  logic [INSN_W-1:0] skid_data;

  assign redir     = redirect_valid & ~stall;
  assign imem_req  = rst_n & (state_q == ST_FETCH) & ~redir;
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    deliver_rsp = 1'b0;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_drop   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redir) begin
          pc_d = redirect_pc;
        end else if (accept) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redir) pc_d = redirect_pc;
        if (imem_rvalid) begin
          state_d = ST_FETCH;
          if (discard_q || redir) begin
            discard_d = 1'b0;
          end else if (!stall) begin
            deliver_rsp = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (redir) begin
          // Response still in flight; remember to throw it away.
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          skid_drop = 1'b1;
          pc_d      = redirect_pc;
          state_d   = ST_FETCH;
        end else if (!stall) begin
          skid_drain = skid_full;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // pc_q already points past the in-flight word, so it is that word's PC+4.
  always_comb begin
    valid_d = valid_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (!stall) begin
      valid_d = 1'b0;
      pc4_d   = '0;
      instr_d = INSN_W'(INSN_NOP);
      if (deliver_rsp) begin
        valid_d = 1'b1;
        pc4_d   = pc_q;
        instr_d = imem_rdata;
      end else if (skid_drain) begin
        valid_d = 1'b1;
        pc4_d   = pc_q;
        instr_d = skid_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      instr_q   <= instr_d;
    end
  end

  ifid_skid #(.W(INSN_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .drop_i  (skid_drop),
    .data_i  (imem_rdata),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  assign ifid_valid = valid_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_instr = instr_q;
  assign ifid_rs    = instr_q[RS_HI:RS_LO];
  assign ifid_rt    = instr_q[RT_HI:RT_LO];
  assign ifid_br    = valid_q & is_branch(instr_q);

`ifdef IF_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stall/redirect/ready,
// checked against a transaction-level model of fetch requests and IF/ID.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_br;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc4       (ifid_pc4),
    .ifid_instr     (ifid_instr),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .ifid_br        (ifid_br)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // imem responder
  int          lat = 1;
  int          cnt = 0;
  bit          pend = 0;
  logic [31:0] paddr = '0;

  // reference model: one transaction in flight, one parked word, IF/ID
  logic [31:0] exp_addr;
  bit          m_busy, m_killed, m_have;
  logic [31:0] m_oaddr, m_word, m_wpc4;
  logic        m_v;
  logic [31:0] m_pc4, m_ins;
  logic [31:0] hs_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80) return {6'b000100, 5'd1, 5'd2, 16'h0003};
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_addr = 32'h0;
    m_busy = 0; m_killed = 0; m_have = 0;
    m_oaddr = '0; m_word = '0; m_wpc4 = '0;
    m_v = 1'b0; m_pc4 = '0; m_ins = '0;
    pend = 0; cnt = 0;
    imem_rvalid = 1'b0;
  endtask

  task automatic tick();
    logic        s_stall, s_redir, s_rv, s_hs;
    logic [31:0] s_tgt, s_a;
    logic        exp_br;
    @(negedge clk);
    s_stall = stall;
    s_redir = redirect_valid & ~stall;
    s_tgt   = redirect_pc;
    s_rv    = imem_rvalid;
    s_hs    = imem_req & imem_ready;
    s_a     = imem_addr;
    chk("imem_req", 32'(imem_req),
        32'(rst_n && !m_busy && !s_redir));
    if (s_hs) begin
      chk("req_addr", s_a, exp_addr);
      hs_log.push_back(s_a);
    end
    @(posedge clk);
    #1;
    if (s_redir) begin
      exp_addr = s_tgt;
      if (m_busy) begin
        if (m_have) begin
          m_have = 0;
          m_busy = 0;
        end else m_killed = 1;
      end
    end
    if (s_rv && m_busy && !m_have) begin
      if (m_killed) m_busy = 0;
      else begin
        m_have = 1;
        m_word = mem_word(m_oaddr);
        m_wpc4 = m_oaddr + 32'd4;
      end
    end
    if (!s_stall) begin
      if (!s_redir && m_have) begin
        m_v = 1'b1; m_pc4 = m_wpc4; m_ins = m_word;
        m_have = 0; m_busy = 0;
      end else begin
        m_v = 1'b0; m_pc4 = '0; m_ins = '0;
      end
    end
    if (s_hs) begin
      m_busy = 1; m_killed = 0; m_oaddr = s_a;
      exp_addr = s_a + 32'd4;
    end
    if (imem_rvalid) pend = 0;
    if (s_hs) begin
      pend = 1; cnt = lat; paddr = s_a;
    end
    if (pend) begin
      cnt--;
      imem_rvalid = (cnt == 0);
    end else imem_rvalid = 1'b0;
    imem_rdata = imem_rvalid ? mem_word(paddr) : $urandom;
    exp_br = m_v && (m_ins[31:26] == 6'b000100 || m_ins[31:26] == 6'b000101);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_instr", ifid_instr, m_ins);
    chk("ifid_rs", 32'(ifid_rs), 32'(m_ins[25:21]));
    chk("ifid_rt", 32'(ifid_rt), 32'(m_ins[20:16]));
    chk("ifid_br", 32'(ifid_br), 32'(exp_br));
  endtask

  task automatic wait_hs();
    int n = hs_log.size();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hs_log.size() > n) return;
    end
    chk("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ifid_valid === 1'b1) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_pc4;
    model_reset();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    lat = 1;

    // 1: back-to-back fetch, latency 1
    repeat (7) tick();
    chk("t1_a0", hs_log[0], 32'h0);
    chk("t1_a1", hs_log[1], 32'h4);
    chk("t1_a2", hs_log[2], 32'h8);

    // 2: stall while the response lands -> skid, then drain
    wait_hs();
    stall = 1'b1;
    repeat (3) tick();
    chk("t2_frozen_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    tick();
    chk("t2_skid_valid", 32'(ifid_valid), 32'd1);
    chk("t2_skid_word", ifid_instr, mem_word(hs_log[$]));

    // 3: redirect in WAIT, response one cycle later is dropped
    lat = 2;
    wait_hs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t3_dropped", 32'(ifid_valid), 32'd0);
    wait_hs();
    chk("t3_target", hs_log[$], 32'h40);

    // 4: redirect under stall is ignored
    lat = 1;
    wait_valid();
    held_pc4 = ifid_pc4;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    repeat (2) tick();
    chk("t4_hold_pc4", ifid_pc4, held_pc4);
    chk("t4_hold_valid", 32'(ifid_valid), 32'd1);
    redirect_valid = 1'b0;
    stall = 1'b0;
    wait_hs();
    chk("t4_no_redir", 32'(hs_log[$] != 32'h200), 32'd1);

    // 5: BEQ $1,$2 decode, then bubble
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    wait_valid();
    chk("t5_br", 32'(ifid_br), 32'd1);
    chk("t5_rs", 32'(ifid_rs), 32'd1);
    chk("t5_rt", 32'(ifid_rt), 32'd2);
    tick();
    chk("t5_bub_br", 32'(ifid_br), 32'd0);
    chk("t5_bub_rs", 32'(ifid_rs), 32'd0);
    chk("t5_bub_rt", 32'(ifid_rt), 32'd0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_hs();
    wait_hs();
    chk("wrap_addr", hs_log[$], 32'h0);

    // 6: async reset mid-WAIT with a live IF/ID entry
    lat = 3;
    wait_valid();
    stall = 1'b1;
    tick();
    chk("t6_live", 32'(ifid_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(ifid_valid), 32'd0);
    chk("t6_pc4", ifid_pc4, 32'd0);
    chk("t6_instr", ifid_instr, 32'd0);
    chk("t6_br", 32'(ifid_br), 32'd0);
    model_reset();
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_hs();
    chk("t6_restart", hs_log[$], 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                 : ($urandom & 32'h0000_FFFC);
      imem_ready = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(1, 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
